// File: rtl/orb_lb_pkg.sv
// Shared defaults and helpers for the ORB/BRIEF multi-line tap buffer.
package orb_lb_pkg;

  localparam int unsigned LB_DATA_W    = 8;
  localparam int unsigned LB_NUM_LINES = 7;
  localparam int unsigned LB_MAX_LINE  = 1024;

  typedef logic [LB_DATA_W-1:0] pixel_t;

  // Bank holding the line k rows above the line currently written to bank idx.
  function automatic int unsigned bank_sub(input int unsigned idx,
                                           input int unsigned k,
                                           input int unsigned nb);
    return (idx + nb - (k % nb)) % nb;
  endfunction

endpackage

// File: rtl/lb_sdp_ram.sv
// Simple dual-port line store: one write port, one registered read-first read port.
module lb_sdp_ram #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 1024,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read returns the pre-write contents when both ports hit the same address.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/line_tap_buffer.sv
// Multi-line delay buffer presenting a vertical column of NUM_LINES pixel taps per cycle.
module line_tap_buffer
  import orb_lb_pkg::*;
#(
  parameter  int unsigned DATA_W    = LB_DATA_W,
  parameter  int unsigned NUM_LINES = LB_NUM_LINES,
  parameter  int unsigned MAX_LINE  = LB_MAX_LINE,
  localparam int unsigned COL_W     = $clog2(MAX_LINE)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_sof,
  input  logic [DATA_W-1:0]           i_data,
  input  logic [COL_W:0]              i_line_len,
  output logic                        o_valid,
  output logic [NUM_LINES*DATA_W-1:0] o_taps,
  output logic [COL_W-1:0]            o_col,
  output logic                        o_rows_ready
);

  localparam int unsigned B      = NUM_LINES - 1;
  localparam int unsigned BANK_W = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned SEEN_W = $clog2(B + 1);
  localparam int unsigned LEN_W  = COL_W + 1;

  // Raster position / frame state
  logic [COL_W-1:0]  col_q,       col_d;
  logic [BANK_W-1:0] wr_row_q,    wr_row_d;
  logic [SEEN_W-1:0] rows_seen_q, rows_seen_d;
  logic [LEN_W-1:0]  line_len_q,  line_len_d;

  // Presentation stage, aligned with the RAM read data
  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] pix_q,       pix_d;
  logic [BANK_W-1:0] sel_row_q,   sel_row_d;
  logic [SEEN_W-1:0] sel_seen_q,  sel_seen_d;
  logic              ready_q,     ready_d;
  logic [COL_W-1:0]  out_col_q,   out_col_d;

  // Position of the pixel being accepted this cycle (SOF overrides the counters)
  logic [COL_W-1:0]  cur_col_c;
  logic [BANK_W-1:0] cur_row_c;
  logic [SEEN_W-1:0] cur_seen_c;
  logic [LEN_W-1:0]  len_clamp_c;
  logic              ram_re_c;

  logic [DATA_W-1:0] ram_rd [B];

  // Counter advance, SOF restart, line-length latch and presentation-stage capture.
  always_comb begin
    col_d       = col_q;
    wr_row_d    = wr_row_q;
    rows_seen_d = rows_seen_q;
    line_len_d  = line_len_q;
    valid_d     = i_en;
    pix_d       = pix_q;
    sel_row_d   = sel_row_q;
    sel_seen_d  = sel_seen_q;
    ready_d     = ready_q;
    out_col_d   = out_col_q;
    cur_col_c   = col_q;
    cur_row_c   = wr_row_q;
    cur_seen_c  = rows_seen_q;

    len_clamp_c = i_line_len;
    if ((i_line_len < LEN_W'(2)) || (i_line_len > LEN_W'(MAX_LINE))) begin
      len_clamp_c = LEN_W'(MAX_LINE);
    end

    if (i_en) begin
      if (i_sof) begin
        cur_col_c   = '0;
        cur_row_c   = '0;
        cur_seen_c  = '0;
        line_len_d  = len_clamp_c;
        col_d       = COL_W'(1);
        wr_row_d    = '0;
        rows_seen_d = '0;
      end else if ({1'b0, col_q} == (line_len_q - LEN_W'(1))) begin
        col_d    = '0;
        wr_row_d = (wr_row_q == BANK_W'(B - 1)) ? '0 : (wr_row_q + BANK_W'(1));
        if (rows_seen_q != SEEN_W'(B)) begin
          rows_seen_d = rows_seen_q + SEEN_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end

      pix_d      = i_data;
      sel_row_d  = cur_row_c;
      sel_seen_d = cur_seen_c;
      ready_d    = (cur_seen_c == SEEN_W'(B));
      out_col_d  = cur_col_c;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q       <= '0;
      wr_row_q    <= '0;
      rows_seen_q <= '0;
      line_len_q  <= LEN_W'(MAX_LINE);
      valid_q     <= 1'b0;
      pix_q       <= '0;
      sel_row_q   <= '0;
      sel_seen_q  <= '0;
      ready_q     <= 1'b0;
      out_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      wr_row_q    <= wr_row_d;
      rows_seen_q <= rows_seen_d;
      line_len_q  <= line_len_d;
      valid_q     <= valid_d;
      pix_q       <= pix_d;
      sel_row_q   <= sel_row_d;
      sel_seen_q  <= sel_seen_d;
      ready_q     <= ready_d;
      out_col_q   <= out_col_d;
    end
  end

  assign ram_re_c = i_en & ~i_rst;

  // One line store per bank; all read the current column, only the current row's bank writes.
  for (genvar b = 0; b < B; b++) begin : g_bank
    lb_sdp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_LINE)
    ) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_re_c && (cur_row_c == BANK_W'(b))),
      .i_waddr (cur_col_c),
      .i_wdata (i_data),
      .i_re    (ram_re_c),
      .i_raddr (cur_col_c),
      .o_rdata (ram_rd[b])
    );
  end

  // Rotate bank outputs into line order and blank lines not yet seen in this frame.
  always_comb begin
    o_taps             = '0;
    o_taps[DATA_W-1:0] = pix_q;
    for (int unsigned k = 1; k <= B; k++) begin
      if (SEEN_W'(k) <= sel_seen_q) begin
        o_taps[k*DATA_W +: DATA_W] = ram_rd[BANK_W'(bank_sub(32'(sel_row_q), k, B))];
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_col        = out_col_q;
  assign o_rows_ready = ready_q;

endmodule

// File: tb/tb_line_tap_buffer.sv
// Self-checking bench for line_tap_buffer against a frame-array reference model.
module tb_line_tap_buffer;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NUM_LINES = 3;
  localparam int unsigned MAX_LINE  = 16;
  localparam int unsigned COL_W     = 4;
  localparam int unsigned B         = NUM_LINES - 1;
  localparam int unsigned TAP_W     = NUM_LINES * DATA_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               sof;
  logic [DATA_W-1:0]  data;
  logic [COL_W:0]     line_len;
  logic               o_valid;
  logic [TAP_W-1:0]   o_taps;
  logic [COL_W-1:0]   o_col;
  logic               o_rows_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: absolute (row, col) position in the current frame plus every pixel seen.
  logic [DATA_W-1:0] frame [64][MAX_LINE];
  int                m_row;
  int                m_col;
  int                m_len;
  logic              exp_valid;
  logic [TAP_W-1:0]  exp_taps;
  logic [COL_W-1:0]  exp_col;
  logic              exp_ready;

  line_tap_buffer #(
    .DATA_W    (DATA_W),
    .NUM_LINES (NUM_LINES),
    .MAX_LINE  (MAX_LINE)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_sof        (sof),
    .i_data       (data),
    .i_line_len   (line_len),
    .o_valid      (o_valid),
    .o_taps       (o_taps),
    .o_col        (o_col),
    .o_rows_ready (o_rows_ready)
  );

  always #5 clk = ~clk;

  // Drive one cycle, then advance the model to what the outputs must show after that edge.
  task automatic step(input logic r, input logic e, input logic s,
                      input logic [DATA_W-1:0] d, input logic [COL_W:0] l);
    rst = r; en = e; sof = s; data = d; line_len = l;
    @(posedge clk);
    #1;
    if (r) begin
      m_row = 0; m_col = 0; m_len = int'(MAX_LINE);
      exp_valid = 1'b0; exp_taps = '0; exp_col = '0; exp_ready = 1'b0;
    end else if (e) begin
      if (s) begin
        m_row = 0; m_col = 0;
        m_len = (int'(l) < 2 || int'(l) > int'(MAX_LINE)) ? int'(MAX_LINE) : int'(l);
      end
      frame[m_row % 64][m_col] = d;
      exp_taps = '0;
      exp_taps[DATA_W-1:0] = d;
      for (int k = 1; k <= int'(B); k++) begin
        if (m_row >= k) exp_taps[k*DATA_W +: DATA_W] = frame[(m_row - k) % 64][m_col];
      end
      exp_col   = COL_W'(m_col);
      exp_ready = (m_row >= int'(B));
      exp_valid = 1'b1;
      m_col++;
      if (m_col >= m_len) begin
        m_col = 0;
        m_row++;
      end
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'($urandom), 5'd4);
      n_checks++;
      if ({o_valid, o_rows_ready, o_taps} !== {1'b0, 1'b0, 24'h0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got v=%b rdy=%b taps=%h expected v=0 rdy=0 taps=000000",
                 i, o_valid, o_rows_ready, o_taps);
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 5'd4);
  endtask

  task automatic test_fill();
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        step(1'b0, 1'b1, (row == 0 && col == 0), 8'(row * 16 + col), 5'd4);
        n_checks++;
        if ({o_valid, o_rows_ready, o_col, o_taps} !== {exp_valid, exp_ready, exp_col, exp_taps}) begin
          n_fail++;
          $display("FAIL fill r%0d c%0d: got v=%b rdy=%b col=%0d taps=%h expected v=%b rdy=%b col=%0d taps=%h",
                   row, col, o_valid, o_rows_ready, o_col, o_taps, exp_valid, exp_ready, exp_col, exp_taps);
        end
        if (row == 2 && col == 3) begin
          n_checks++;
          if (o_taps !== 24'h031323) begin
            n_fail++;
            $display("FAIL fill_r2c3: got taps=%h expected 031323", o_taps);
          end
        end
        if ((row == 1 && col == 3) || (row == 2 && col == 0)) begin
          n_checks++;
          if (o_rows_ready !== (row == 2)) begin
            n_fail++;
            $display("FAIL fill_ready r%0d c%0d: got %b expected %b", row, col, o_rows_ready, (row == 2));
          end
        end
      end
    end
  endtask

  task automatic test_gaps();
    for (int p = 0; p < 16; p++) begin
      while ($urandom_range(1, 0) == 1) begin
        step(1'b0, 1'b0, 1'b0, 8'($urandom), 5'($urandom));
        n_checks++;
        if ({o_valid, o_rows_ready, o_col, o_taps} !== {exp_valid, exp_ready, exp_col, exp_taps}) begin
          n_fail++;
          $display("FAIL gaps_idle p%0d: got v=%b rdy=%b col=%0d taps=%h expected v=%b rdy=%b col=%0d taps=%h",
                   p, o_valid, o_rows_ready, o_col, o_taps, exp_valid, exp_ready, exp_col, exp_taps);
        end
      end
      step(1'b0, 1'b1, (p == 0), 8'((p / 4) * 16 + (p % 4)), 5'd4);
      n_checks++;
      if ({o_valid, o_rows_ready, o_col, o_taps} !== {exp_valid, exp_ready, exp_col, exp_taps}) begin
        n_fail++;
        $display("FAIL gaps_pix p%0d: got v=%b rdy=%b col=%0d taps=%h expected v=%b rdy=%b col=%0d taps=%h",
                 p, o_valid, o_rows_ready, o_col, o_taps, exp_valid, exp_ready, exp_col, exp_taps);
      end
      if (p == 11) begin
        n_checks++;
        if (o_taps !== 24'h031323) begin
          n_fail++;
          $display("FAIL gaps_r2c3: got taps=%h expected 031323", o_taps);
        end
      end
    end
  endtask

  task automatic test_mid_sof();
    for (int p = 0; p < 9; p++) step(1'b0, 1'b1, (p == 0), 8'($urandom), 5'd4);
    step(1'b0, 1'b1, 1'b1, 8'($urandom), 5'd6);
    n_checks++;
    if ({o_valid, o_rows_ready, o_col, o_taps[TAP_W-1:DATA_W]} !== {1'b1, 1'b0, 4'd0, 16'h0}) begin
      n_fail++;
      $display("FAIL mid_sof: got v=%b rdy=%b col=%0d upper_taps=%h expected v=1 rdy=0 col=0 upper_taps=0000",
               o_valid, o_rows_ready, o_col, o_taps[TAP_W-1:DATA_W]);
    end
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 1'b1, 1'b0, 8'($urandom), 5'd4);
      n_checks++;
      if ({o_valid, o_rows_ready, o_col, o_taps} !== {exp_valid, exp_ready, exp_col, exp_taps}) begin
        n_fail++;
        $display("FAIL mid_sof_run j%0d: got v=%b rdy=%b col=%0d taps=%h expected v=%b rdy=%b col=%0d taps=%h",
                 j, o_valid, o_rows_ready, o_col, o_taps, exp_valid, exp_ready, exp_col, exp_taps);
      end
      n_checks++;
      if (o_col !== 4'(j % 6)) begin
        n_fail++;
        $display("FAIL mid_sof_col j%0d: got col=%0d expected %0d", j, o_col, j % 6);
      end
    end
  endtask

  task automatic test_clamp();
    logic [COL_W:0] lens [3];
    lens[0] = 5'd0; lens[1] = 5'd1; lens[2] = 5'd20;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < int'(MAX_LINE) + 2; i++) begin
        step(1'b0, 1'b1, (i == 0), 8'($urandom), (i == 0) ? lens[t] : 5'($urandom_range(2, 6)));
        n_checks++;
        if ({o_valid, o_rows_ready, o_col, o_taps} !== {exp_valid, exp_ready, exp_col, exp_taps}) begin
          n_fail++;
          $display("FAIL clamp len%0d i%0d: got v=%b rdy=%b col=%0d taps=%h expected v=%b rdy=%b col=%0d taps=%h",
                   lens[t], i, o_valid, o_rows_ready, o_col, o_taps, exp_valid, exp_ready, exp_col, exp_taps);
        end
        n_checks++;
        if (o_col !== 4'(i % int'(MAX_LINE))) begin
          n_fail++;
          $display("FAIL clamp_col len%0d i%0d: got col=%0d expected %0d", lens[t], i, o_col, i % int'(MAX_LINE));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 14; p++) step(1'b0, 1'b1, (p == 0), 8'($urandom), 5'd4);
    step(1'b1, 1'b1, 1'b0, 8'($urandom), 5'd4);
    step(1'b0, 1'b1, 1'b0, 8'($urandom), 5'd4);
    n_checks++;
    if ({o_valid, o_rows_ready, o_col, o_taps[TAP_W-1:DATA_W]} !== {1'b1, 1'b0, 4'd0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b rdy=%b col=%0d upper_taps=%h expected v=1 rdy=0 col=0 upper_taps=0000",
               o_valid, o_rows_ready, o_col, o_taps[TAP_W-1:DATA_W]);
    end
    for (int j = 1; j < 20; j++) begin
      step(1'b0, 1'b1, 1'b0, 8'($urandom), 5'd4);
      n_checks++;
      if ({o_valid, o_rows_ready, o_col, o_taps} !== {exp_valid, exp_ready, exp_col, exp_taps}) begin
        n_fail++;
        $display("FAIL reset_mid_run j%0d: got v=%b rdy=%b col=%0d taps=%h expected v=%b rdy=%b col=%0d taps=%h",
                 j, o_valid, o_rows_ready, o_col, o_taps, exp_valid, exp_ready, exp_col, exp_taps);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int len;
      int rows;
      int sent;
      len  = $urandom_range(8, 2);
      rows = $urandom_range(5, 2);
      sent = 0;
      while (sent < len * rows) begin
        logic e;
        e = 1'($urandom_range(1, 0));
        step(1'b0, e, (e && sent == 0), 8'($urandom), (sent == 0) ? 5'(len) : 5'($urandom));
        if (e) sent++;
        n_checks++;
        if ({o_valid, o_rows_ready, o_col, o_taps} !== {exp_valid, exp_ready, exp_col, exp_taps}) begin
          n_fail++;
          $display("FAIL random f%0d n%0d: got v=%b rdy=%b col=%0d taps=%h expected v=%b rdy=%b col=%0d taps=%h",
                   f, sent, o_valid, o_rows_ready, o_col, o_taps, exp_valid, exp_ready, exp_col, exp_taps);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sof = 1'b0; data = '0; line_len = '0;
    m_row = 0; m_col = 0; m_len = int'(MAX_LINE);
    exp_valid = 1'b0; exp_taps = '0; exp_col = '0; exp_ready = 1'b0;
    test_reset();
    test_fill();
    test_gaps();
    test_mid_sof();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
